// File: rtl/m68k_bus_responder_pkg.sv
// Shared encodings for the 68k bus responder: FSM states, DSACK codes and
// the byte-lane decode used when a cycle is captured.
package m68k_bus_responder_pkg;

    // Responder FSM states (4-bit, also exported on the debug state port).
    localparam logic [3:0] RSP_IDLE    = 4'd0;
    localparam logic [3:0] RSP_DECODE  = 4'd1;
    localparam logic [3:0] RSP_IGNORE  = 4'd2;
    localparam logic [3:0] RSP_WAIT_DS = 4'd3;
    localparam logic [3:0] RSP_STROBE  = 4'd4;
    localparam logic [3:0] RSP_ACCESS  = 4'd5;
    localparam logic [3:0] RSP_WAITST  = 4'd6;
    localparam logic [3:0] RSP_ACK     = 4'd7;
    localparam logic [3:0] RSP_RELEASE = 4'd8;
    localparam logic [3:0] RSP_ERROR   = 4'd9;

    // DSACK encodings for a 16-bit port (active low pair).
    localparam logic [1:0] DSACK_ASSERT_16 = 2'b01;
    localparam logic [1:0] DSACK_IDLE      = 2'b11;

    // Byte lanes {upper,lower}: a byte transfer picks one lane from A0,
    // every other size code is handled as a full word.
    function automatic logic [1:0] byte_enables(input logic [1:0] siz, input logic a0);
        logic [1:0] be;
        if (siz == 2'b01) begin
            be = a0 ? 2'b01 : 2'b10;
        end else begin
            be = 2'b11;
        end
        return be;
    endfunction

endpackage

// File: rtl/m68k_bus_responder_bus_sync.sv
// Two-flop synchronizer for asynchronous bus strobes. Resets to RESET_VAL so
// active-low strobes come out of reset in their negated state.
module m68k_bus_responder_bus_sync #(
    parameter int              WIDTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    // Two register stages: first may go metastable, second is used by logic.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= RESET_VAL;
            synced <= RESET_VAL;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/m68k_bus_responder.sv
// 68k-style asynchronous bus target. Synchronizes AS/DS, decodes a register
// window, issues a single-cycle register request and terminates the bus cycle
// with DSACK (or BERR on timeout), then waits for AS to be negated.
//
// Register-side handshake: REG_RE/REG_WE is a one-cycle request with REG_ADDR,
// REG_BE and REG_WDATA stable while it is high. REG_READY is the completion;
// it may already be high in the request cycle, otherwise it is awaited in
// ACCESS. REG_RDATA is only sampled in a cycle where REG_READY is high.
// Ready arriving outside STROBE/ACCESS is ignored.
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 24'hE80000,
    parameter int                    WINDOW_BITS = 8,
    parameter int                    WAIT_STATES = 2,
    parameter int                    TIMEOUT     = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   AS_n,
    input  logic                   DS_n,
    input  logic                   RW,
    input  logic [1:0]             SIZ,
    input  logic [ADDR_WIDTH-1:0]  ADDR,
    input  logic [15:0]            DATA_IN,
    output logic [15:0]            DATA_OUT,
    output logic                   DATA_OE,
    output logic [1:0]             DSACK_n,
    output logic                   BERR_n,
    output logic [WINDOW_BITS-2:0] REG_ADDR,
    output logic [1:0]             REG_BE,
    output logic                   REG_WE,
    output logic                   REG_RE,
    output logic [15:0]            REG_WDATA,
    input  logic [15:0]            REG_RDATA,
    input  logic                   REG_READY,
    output logic [3:0]             fsm_state
);

    localparam int TAG_WIDTH = ADDR_WIDTH - WINDOW_BITS;
    localparam logic [TAG_WIDTH-1:0] BASE_TAG = BASE_ADDR[ADDR_WIDTH-1:WINDOW_BITS];
    // Last count value of the wait-state and timeout counters.
    localparam logic [7:0] WS_LAST  = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]           strobe_sync;
    logic                 as_act;
    logic                 ds_act;
    logic [3:0]           state;
    logic [3:0]           next_state;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 rw_q;
    logic                 ready_q;
    logic [15:0]          rdata_q;
    logic                 ready_now;
    logic                 hit;
    logic [7:0]           wait_cnt;
    logic [7:0]           tmo_cnt;

    m68k_bus_responder_bus_sync #(
        .WIDTH     (2),
        .RESET_VAL (2'b11)
    ) u_bus_sync (
        .clk    (CLK),
        .reset  (RESET),
        .raw    ({AS_n, DS_n}),
        .synced (strobe_sync)
    );

    assign as_act    = ~strobe_sync[1];
    assign ds_act    = ~strobe_sync[0];
    assign hit       = (tag_q == BASE_TAG);
    // Completion seen either during the strobe cycle (latched) or now.
    assign ready_now = ready_q | REG_READY;
    assign fsm_state = state;

    // Next-state decode; AS negation aborts any cycle before termination.
    always_comb begin
        next_state = state;
        case (state)
            RSP_IDLE:    if (as_act) next_state = RSP_DECODE;
            RSP_DECODE:  next_state = hit ? RSP_WAIT_DS : RSP_IGNORE;
            RSP_IGNORE:  if (!as_act) next_state = RSP_IDLE;
            RSP_WAIT_DS: begin
                if (!as_act)     next_state = RSP_IDLE;
                else if (ds_act) next_state = RSP_STROBE;
            end
            RSP_STROBE:  next_state = as_act ? RSP_ACCESS : RSP_IDLE;
            RSP_ACCESS: begin
                if (!as_act)                next_state = RSP_IDLE;
                else if (ready_now)         next_state = (WAIT_STATES == 0) ? RSP_ACK : RSP_WAITST;
                else if (tmo_cnt == TMO_LAST) next_state = RSP_ERROR;
            end
            RSP_WAITST: begin
                if (!as_act)                next_state = RSP_IDLE;
                else if (wait_cnt == WS_LAST) next_state = RSP_ACK;
            end
            RSP_ACK:     next_state = RSP_RELEASE;
            RSP_RELEASE: if (!as_act) next_state = RSP_IDLE;
            RSP_ERROR:   if (!as_act) next_state = RSP_IDLE;
            default:     next_state = RSP_IDLE;
        endcase
    end

    // State register, captured cycle attributes, counters and registered bus/register outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= RSP_IDLE;
            tag_q     <= '0;
            rw_q      <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            tmo_cnt   <= '0;
            DATA_OUT  <= '0;
            DATA_OE   <= 1'b0;
            DSACK_n   <= DSACK_IDLE;
            BERR_n    <= 1'b1;
            REG_ADDR  <= '0;
            REG_BE    <= '0;
            REG_WE    <= 1'b0;
            REG_RE    <= 1'b0;
            REG_WDATA <= '0;
        end else begin
            state  <= next_state;
            REG_WE <= 1'b0;
            REG_RE <= 1'b0;

            case (state)
                RSP_IDLE: begin
                    // Address phase is captured when synced AS is first seen.
                    if (next_state == RSP_DECODE) begin
                        tag_q    <= ADDR[ADDR_WIDTH-1:WINDOW_BITS];
                        rw_q     <= RW;
                        REG_ADDR <= ADDR[WINDOW_BITS-1:1];
                        REG_BE   <= byte_enables(SIZ, ADDR[0]);
                    end
                end
                RSP_WAIT_DS: begin
                    if (next_state == RSP_STROBE) begin
                        REG_WDATA <= DATA_IN;
                        REG_WE    <= ~rw_q;
                        REG_RE    <= rw_q;
                    end
                end
                RSP_STROBE: begin
                    ready_q <= REG_READY;
                    rdata_q <= REG_RDATA;
                    tmo_cnt <= '0;
                end
                RSP_ACCESS: begin
                    if (next_state == RSP_WAITST || next_state == RSP_ACK) begin
                        wait_cnt <= '0;
                        if (rw_q) begin
                            DATA_OUT <= ready_q ? rdata_q : REG_RDATA;
                            DATA_OE  <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RSP_WAITST: wait_cnt <= wait_cnt + 8'd1;
                default: ;
            endcase

            if (next_state == RSP_ACK) begin
                DSACK_n <= DSACK_ASSERT_16;
            end
            if (next_state == RSP_ERROR) begin
                BERR_n  <= 1'b0;
                DATA_OE <= 1'b0;
            end
            // Returning to (or staying in) IDLE releases every bus output.
            if (next_state == RSP_IDLE) begin
                DSACK_n  <= DSACK_IDLE;
                BERR_n   <= 1'b1;
                DATA_OE  <= 1'b0;
                DATA_OUT <= '0;
                ready_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: reads, byte write, window miss,
// ready timeout, abort during ACCESS and reset while DSACK is held.
module tb_m68k_bus_responder;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_IGNORE  = 4'd2;
    localparam logic [3:0] S_ACCESS  = 4'd5;
    localparam logic [3:0] S_RELEASE = 4'd8;
    localparam logic [3:0] S_ERROR   = 4'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n, ds_n, rw;
    logic [1:0]  siz;
    logic [23:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic [1:0]  dsack_n;
    logic        berr_n;
    logic [6:0]  reg_addr;
    logic [1:0]  reg_be;
    logic        reg_we, reg_re;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        reg_ready;
    logic [3:0]  fsm_state;

    // Register-file stand-in: auto mode answers in the strobe cycle.
    logic rf_auto;
    logic ready_force;
    assign reg_ready = (rf_auto && (reg_re || reg_we)) || ready_force;

    int n_vec = 0;
    int n_err = 0;

    // Monitor results
    int          re_cnt, we_cnt, excl_err, bad_dsack;
    bit          ds_seen, berr_seen, oe_seen;
    logic [6:0]  st_addr;
    logic [1:0]  st_be;
    logic [15:0] st_wdata;

    m68k_bus_responder #(
        .ADDR_WIDTH  (24),
        .BASE_ADDR   (24'hE80000),
        .WINDOW_BITS (8),
        .WAIT_STATES (2),
        .TIMEOUT     (255)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .AS_n      (as_n),
        .DS_n      (ds_n),
        .RW        (rw),
        .SIZ       (siz),
        .ADDR      (addr),
        .DATA_IN   (data_in),
        .DATA_OUT  (data_out),
        .DATA_OE   (data_oe),
        .DSACK_n   (dsack_n),
        .BERR_n    (berr_n),
        .REG_ADDR  (reg_addr),
        .REG_BE    (reg_be),
        .REG_WE    (reg_we),
        .REG_RE    (reg_re),
        .REG_WDATA (reg_wdata),
        .REG_RDATA (reg_rdata),
        .REG_READY (reg_ready),
        .fsm_state (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (reg_re) begin
            re_cnt++;
            st_addr = reg_addr;
            st_be   = reg_be;
        end
        if (reg_we) begin
            we_cnt++;
            st_addr  = reg_addr;
            st_be    = reg_be;
            st_wdata = reg_wdata;
        end
        if (dsack_n == 2'b01) ds_seen = 1'b1;
        if (dsack_n != 2'b01 && dsack_n != 2'b11) bad_dsack++;
        if (!berr_n) berr_seen = 1'b1;
        if (!berr_n && dsack_n != 2'b11) excl_err++;
        if (data_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        re_cnt = 0; we_cnt = 0;
        ds_seen = 1'b0; berr_seen = 1'b0; oe_seen = 1'b0;
        st_addr = '0; st_be = '0; st_wdata = '0;
    endtask

    // Drivers: assert/negate a bus cycle on the falling edge.
    task automatic bus_start(input logic [23:0] a, input logic r, input logic [1:0] s, input logic [15:0] d);
        @(negedge clk);
        addr = a; rw = r; siz = s; data_in = d;
        as_n = 1'b0; ds_n = 1'b0;
    endtask

    task automatic bus_end();
        @(negedge clk);
        as_n = 1'b1; ds_n = 1'b1;
    endtask

    task automatic wait_dsack(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (dsack_n == 2'b01) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (fsm_state == s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int k;

        reset = 1'b1; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1; siz = 2'b10;
        addr = '0; data_in = '0; reg_rdata = '0; rf_auto = 1'b1; ready_force = 1'b0;
        excl_err = 0; bad_dsack = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset state
        check("rst_dsack", 32'(dsack_n), 32'h3);
        check("rst_berr", 32'(berr_n), 32'h1);
        check("rst_oe", 32'(data_oe), 32'h0);
        check("rst_dout", 32'(data_out), 32'h0);
        check("rst_we_re", {30'd0, reg_we, reg_re}, 32'h0);
        check("rst_regs", {7'd0, reg_addr, reg_be, reg_wdata}, 32'h0);
        check("rst_state", 32'(fsm_state), 32'(S_IDLE));
        reset = 1'b0;

        // Word read at E80010, ready in strobe cycle
        clear_mon();
        reg_rdata = 16'hBEEF;
        bus_start(24'hE80010, 1'b1, 2'b10, 16'h0000);
        wait_dsack(40, ok);
        check("rd_dsack_to", 32'(ok), 32'h1);
        check("rd_dout", 32'(data_out), 32'hBEEF);
        check("rd_oe", 32'(data_oe), 32'h1);
        repeat (5) @(negedge clk);
        check("rd_hold", 32'(dsack_n), 32'h1);
        check("rd_release_st", 32'(fsm_state), 32'(S_RELEASE));
        check("rd_re_cnt", 32'(re_cnt), 32'd1);
        check("rd_we_cnt", 32'(we_cnt), 32'd0);
        check("rd_addr", 32'(st_addr), 32'h8);
        check("rd_be", 32'(st_be), 32'h3);
        bus_end();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rd_end_dsack", 32'(dsack_n), 32'h3);
        check("rd_end_oe", 32'(data_oe), 32'h0);
        check("rd_end_state", 32'(fsm_state), 32'(S_IDLE));

        // Byte write SIZ=01 at E80005
        clear_mon();
        bus_start(24'hE80005, 1'b0, 2'b01, 16'h00A5);
        wait_dsack(40, ok);
        check("wr_dsack_to", 32'(ok), 32'h1);
        check("wr_we_cnt", 32'(we_cnt), 32'd1);
        check("wr_re_cnt", 32'(re_cnt), 32'd0);
        check("wr_be", 32'(st_be), 32'h1);
        check("wr_wdata", 32'(st_wdata), 32'h00A5);
        check("wr_addr", 32'(st_addr), 32'h2);
        check("wr_no_oe", 32'(oe_seen), 32'h0);
        bus_end();
        repeat (4) @(negedge clk);
        check("wr_end_state", 32'(fsm_state), 32'(S_IDLE));

        // Upper-byte read at E80004 with SIZ=01
        clear_mon();
        reg_rdata = 16'h5A00;
        bus_start(24'hE80004, 1'b1, 2'b01, 16'h0000);
        wait_dsack(40, ok);
        check("ub_dsack_to", 32'(ok), 32'h1);
        check("ub_be", 32'(st_be), 32'h2);
        check("ub_addr", 32'(st_addr), 32'h2);
        check("ub_dout", 32'(data_out), 32'h5A00);
        bus_end();
        repeat (4) @(negedge clk);

        // Miss at DFF000
        clear_mon();
        bus_start(24'hDFF000, 1'b1, 2'b10, 16'h0000);
        repeat (20) @(negedge clk);
        check("miss_state", 32'(fsm_state), 32'(S_IGNORE));
        bus_end();
        repeat (4) @(negedge clk);
        check("miss_strobes", 32'(re_cnt + we_cnt), 32'd0);
        check("miss_dsack", 32'(ds_seen), 32'h0);
        check("miss_berr", 32'(berr_seen), 32'h0);
        check("miss_idle", 32'(fsm_state), 32'(S_IDLE));

        // Timeout: ready never comes
        clear_mon();
        rf_auto = 1'b0;
        bus_start(24'hE80020, 1'b1, 2'b10, 16'h0000);
        wait_state(S_ACCESS, 40, ok);
        check("tmo_access_to", 32'(ok), 32'h1);
        k = 0;
        while (berr_n === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("tmo_cycles", 32'(k), 32'd255);
        check("tmo_state", 32'(fsm_state), 32'(S_ERROR));
        check("tmo_oe", 32'(data_oe), 32'h0);
        check("tmo_no_dsack", 32'(ds_seen), 32'h0);
        bus_end();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tmo_berr_rel", 32'(berr_n), 32'h1);
        check("tmo_idle", 32'(fsm_state), 32'(S_IDLE));

        // Abort during ACCESS, then a late ready pulse
        clear_mon();
        reg_rdata = 16'hDEAD;
        bus_start(24'hE80030, 1'b1, 2'b10, 16'h0000);
        wait_state(S_ACCESS, 40, ok);
        check("abt_access_to", 32'(ok), 32'h1);
        bus_end();
        wait_state(S_IDLE, 10, ok);
        check("abt_idle_to", 32'(ok), 32'h1);
        ready_force = 1'b1;
        @(negedge clk);
        ready_force = 1'b0;
        repeat (10) @(negedge clk);
        check("abt_re_cnt", 32'(re_cnt), 32'd1);
        check("abt_no_dsack", 32'(ds_seen), 32'h0);
        check("abt_no_oe", 32'(oe_seen), 32'h0);
        check("abt_state", 32'(fsm_state), 32'(S_IDLE));

        // Next access completes normally
        clear_mon();
        rf_auto = 1'b1;
        reg_rdata = 16'h1234;
        bus_start(24'hE80002, 1'b1, 2'b11, 16'h0000);
        wait_dsack(40, ok);
        check("nxt_dsack_to", 32'(ok), 32'h1);
        check("nxt_dout", 32'(data_out), 32'h1234);
        check("nxt_addr", 32'(st_addr), 32'h1);
        check("nxt_be", 32'(st_be), 32'h3);
        bus_end();
        repeat (4) @(negedge clk);

        // Reset while in RELEASE with DSACK asserted
        clear_mon();
        reg_rdata = 16'hCAFE;
        bus_start(24'hE800FE, 1'b1, 2'b10, 16'h0000);
        wait_dsack(40, ok);
        check("rr_dsack_to", 32'(ok), 32'h1);
        repeat (2) @(negedge clk);
        check("rr_release", 32'(fsm_state), 32'(S_RELEASE));
        reset = 1'b1;
        @(negedge clk);
        check("rr_dsack", 32'(dsack_n), 32'h3);
        check("rr_oe", 32'(data_oe), 32'h0);
        check("rr_state", 32'(fsm_state), 32'(S_IDLE));
        reset = 1'b0; as_n = 1'b1; ds_n = 1'b1;
        repeat (6) @(negedge clk);
        check("rr_stay_idle", 32'(fsm_state), 32'(S_IDLE));

        // Whole-run invariants
        check("excl_dsack_berr", 32'(excl_err), 32'd0);
        check("dsack_code", 32'(bad_dsack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
